// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions: sequencing-state encodings and logic-level constants.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    IMISS_WAIT = 2'd2,
    DMISS_WAIT = 2'd3
  } pipe_state_e;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard inputs, cache status and stage stall/clear controls between the pipeline and its sequencer.
interface hazard_stall_controller_if
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADD_WIDTH = 5,
  parameter int COUNT_WIDTH   = 16
);
  logic [REG_ADD_WIDTH-1:0] ID_RS1_ADDRESS;
  logic [REG_ADD_WIDTH-1:0] ID_RS2_ADDRESS;
  logic [REG_ADD_WIDTH-1:0] EX_RD_ADDRESS;
  logic                     EX_LOAD;
  logic                     EX_RD_WRITE_ENABLE;
  logic                     BRANCH_TAKEN;
  logic                     ICACHE_READY;
  // Data cache: DCACHE_REQ is the valid of an access in the memory stage; DCACHE_READY is
  // its ready, and the access completes only in a cycle where both are high.
  logic                     DCACHE_REQ;
  logic                     DCACHE_READY;
  logic                     COUNT_CLEAR;

  logic                     STALL_FETCH_STAGE;
  logic                     CLEAR_FETCH_STAGE;
  logic                     STALL_DECODING_STAGE;
  logic                     CLEAR_DECODING_STAGE;
  logic                     STALL_EXECUTION_STAGE;
  logic                     STALL_MEMORY_STAGE;
  pipe_state_e              PIPE_STATE;
  logic [COUNT_WIDTH-1:0]   STALL_COUNT;
  logic [COUNT_WIDTH-1:0]   FLUSH_COUNT;

  modport master (
    output ID_RS1_ADDRESS, ID_RS2_ADDRESS, EX_RD_ADDRESS, EX_LOAD, EX_RD_WRITE_ENABLE,
           BRANCH_TAKEN, ICACHE_READY, DCACHE_REQ, DCACHE_READY, COUNT_CLEAR,
    input  STALL_FETCH_STAGE, CLEAR_FETCH_STAGE, STALL_DECODING_STAGE, CLEAR_DECODING_STAGE,
           STALL_EXECUTION_STAGE, STALL_MEMORY_STAGE, PIPE_STATE, STALL_COUNT, FLUSH_COUNT
  );

  modport slave (
    input  ID_RS1_ADDRESS, ID_RS2_ADDRESS, EX_RD_ADDRESS, EX_LOAD, EX_RD_WRITE_ENABLE,
           BRANCH_TAKEN, ICACHE_READY, DCACHE_REQ, DCACHE_READY, COUNT_CLEAR,
    output STALL_FETCH_STAGE, CLEAR_FETCH_STAGE, STALL_DECODING_STAGE, CLEAR_DECODING_STAGE,
           STALL_EXECUTION_STAGE, STALL_MEMORY_STAGE, PIPE_STATE, STALL_COUNT, FLUSH_COUNT
  );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter
  import hazard_stall_controller_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] value
);
  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){LOW}}, HIGH};

  logic [COUNT_WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (enable && (value_q != '1)) begin
      value_d = value_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;
endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: resolves load-use, branch flush and cache-miss hazards into per-stage
// stall/clear controls (combinational from state and inputs), tracks the pipeline condition.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADD_WIDTH = 5,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  hazard_stall_controller_if.slave pipe
);
  localparam logic [REG_ADD_WIDTH-1:0] ZERO_ADDR = '0;

  pipe_state_e state_q, state_d;
  logic freeze, luse, imiss;
  logic stall_f, clr_f, stall_d, clr_d, stall_e, stall_m;
  logic any_ctl, flush_inc;

  assign freeze = pipe.DCACHE_REQ & ~pipe.DCACHE_READY;
  assign imiss  = ~pipe.ICACHE_READY;
  assign luse   = pipe.EX_LOAD & pipe.EX_RD_WRITE_ENABLE & (pipe.EX_RD_ADDRESS != ZERO_ADDR) &
                  ((pipe.EX_RD_ADDRESS == pipe.ID_RS1_ADDRESS) |
                   (pipe.EX_RD_ADDRESS == pipe.ID_RS2_ADDRESS));

  always_comb begin
    stall_f = LOW;
    clr_f   = LOW;
    stall_d = LOW;
    clr_d   = LOW;
    stall_e = LOW;
    stall_m = LOW;
    if (!RST_N) begin
      clr_f = HIGH;
      clr_d = HIGH;
    end else if (freeze) begin
      // Everything is held; a coincident branch or load-use reappears once EX moves again.
      stall_f = HIGH;
      stall_d = HIGH;
      stall_e = HIGH;
      stall_m = HIGH;
    end else if (pipe.BRANCH_TAKEN) begin
      clr_f = HIGH;
      clr_d = HIGH;
    end else begin
      // Decode holds a killed instruction during FLUSH, so its operands cannot hazard.
      if (luse && (state_q != FLUSH)) begin
        stall_f = HIGH;
        clr_d   = HIGH;
      end
      if (imiss) stall_f = HIGH;
    end
  end

  always_comb begin
    state_d = RUN;
    if (freeze)                 state_d = DMISS_WAIT;
    else if (pipe.BRANCH_TAKEN) state_d = FLUSH;
    else if (imiss)             state_d = IMISS_WAIT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign any_ctl   = stall_f | clr_f | stall_d | clr_d | stall_e | stall_m;
  assign flush_inc = pipe.BRANCH_TAKEN & ~freeze;

  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_stall_count (
    .clk    (CLK),
    .rst_n  (RST_N),
    .enable (any_ctl),
    .clear  (pipe.COUNT_CLEAR),
    .value  (pipe.STALL_COUNT)
  );

  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_flush_count (
    .clk    (CLK),
    .rst_n  (RST_N),
    .enable (flush_inc),
    .clear  (pipe.COUNT_CLEAR),
    .value  (pipe.FLUSH_COUNT)
  );

  assign pipe.STALL_FETCH_STAGE     = stall_f;
  assign pipe.CLEAR_FETCH_STAGE     = clr_f;
  assign pipe.STALL_DECODING_STAGE  = stall_d;
  assign pipe.CLEAR_DECODING_STAGE  = clr_d;
  assign pipe.STALL_EXECUTION_STAGE = stall_e;
  assign pipe.STALL_MEMORY_STAGE    = stall_m;
  assign pipe.PIPE_STATE            = state_q;
endmodule
